// File: rtl/div16u8_seq.sv
// Sequential radix-2 restoring divider: 2*W_D-bit dividend / W_D-bit divisor, one quotient bit
// per cycle, valid/ready on both sides. Define DIV16U8_REM_EN to drive the remainder port.
`timescale 1ns / 1ps

module div16u8_seq #(
  parameter int unsigned W_D = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*W_D-1:0]   dividend,
  input  logic [W_D-1:0]     divisor,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [W_D-1:0]     quotient,
  output logic [W_D-1:0]     remainder,
  output logic               ovf
);

  localparam int unsigned CntW = (W_D > 1) ? $clog2(W_D) : 1;
  localparam logic [CntW-1:0] LastStep = CntW'(W_D - 1);

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } state_e;

  state_e          state_q, state_d;
  logic [W_D-1:0]  rem_q, rem_d;
  logic [W_D-1:0]  sr_q, sr_d;
  logic [W_D-1:0]  div_q, div_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            ovf_pend_q, ovf_pend_d;
  logic            out_valid_q, out_valid_d;
  logic [W_D-1:0]  quot_q, quot_d;
  logic            ovf_q, ovf_d;
`ifdef DIV16U8_REM_EN
  logic [W_D-1:0]  rem_out_q, rem_out_d;
`endif

  logic [W_D-1:0]  hi_in, lo_in;
  logic [W_D:0]    trial, diff;
  logic            qbit;
  logic [W_D-1:0]  rem_step, sr_step;

  assign hi_in = dividend[2*W_D-1:W_D];
  assign lo_in = dividend[W_D-1:0];

  // Partial remainder stays below the divisor, so a 9-bit trial subtraction never loses bits.
  assign trial    = {rem_q, sr_q[W_D-1]};
  assign diff     = trial - {1'b0, div_q};
  assign qbit     = ~diff[W_D];
  assign rem_step = qbit ? diff[W_D-1:0] : trial[W_D-1:0];
  assign sr_step  = {sr_q[W_D-2:0], qbit};

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    sr_d        = sr_q;
    div_d       = div_q;
    cnt_d       = cnt_q;
    ovf_pend_d  = ovf_pend_q;
    out_valid_d = out_valid_q;
    quot_d      = quot_q;
    ovf_d       = ovf_q;
`ifdef DIV16U8_REM_EN
    rem_out_d   = rem_out_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          div_d      = divisor;
          rem_d      = hi_in;
          sr_d       = lo_in;
          cnt_d      = '0;
          ovf_pend_d = (divisor == '0) || (hi_in >= divisor);
          state_d    = StBusy;
        end
      end
      StBusy: begin
        // Overflow spends one BUSY cycle so its latency is a fixed single cycle.
        if (ovf_pend_q) begin
          state_d     = StDone;
          out_valid_d = 1'b1;
          quot_d      = '1;
          ovf_d       = 1'b1;
`ifdef DIV16U8_REM_EN
          rem_out_d   = '0;
`endif
        end else begin
          rem_d = rem_step;
          sr_d  = sr_step;
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q == LastStep) begin
            state_d     = StDone;
            out_valid_d = 1'b1;
            quot_d      = sr_step;
            ovf_d       = 1'b0;
`ifdef DIV16U8_REM_EN
            rem_out_d   = rem_step;
`endif
          end
        end
      end
      StDone: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      rem_q       <= '0;
      sr_q        <= '0;
      div_q       <= '0;
      cnt_q       <= '0;
      ovf_pend_q  <= 1'b0;
      out_valid_q <= 1'b0;
      quot_q      <= '0;
      ovf_q       <= 1'b0;
`ifdef DIV16U8_REM_EN
      rem_out_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      sr_q        <= sr_d;
      div_q       <= div_d;
      cnt_q       <= cnt_d;
      ovf_pend_q  <= ovf_pend_d;
      out_valid_q <= out_valid_d;
      quot_q      <= quot_d;
      ovf_q       <= ovf_d;
`ifdef DIV16U8_REM_EN
      rem_out_q   <= rem_out_d;
`endif
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = out_valid_q;
  assign quotient  = quot_q;
  assign ovf       = ovf_q;
`ifdef DIV16U8_REM_EN
  assign remainder = rem_out_q;
`else
  assign remainder = '0;
`endif

endmodule

// File: tb/tb_div16u8_seq.sv
// Bench for div16u8_seq: directed vectors with literal expectations plus an arithmetic
// reference model and per-cycle output compare (result, latency, in_ready while DONE).
`timescale 1ns / 1ps

module tb_div16u8_seq;

`ifdef DIV16U8_REM_EN
  localparam bit RemEn = 1'b1;
`else
  localparam bit RemEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] dividend = '0;
  logic [7:0]  divisor = '0;
  logic        in_ready, out_valid, ovf;
  logic [7:0]  quotient, remainder;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       o;
    int         acc;
  } exp_t;

  exp_t exp_q[$];

  div16u8_seq #(.W_D(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  function automatic exp_t model(input logic [15:0] a, input logic [7:0] b, input int acc);
    exp_t e;
    int unsigned qi;
    e.acc = acc;
    e.q = 8'hFF;
    e.r = 8'h00;
    e.o = 1'b1;
    if (b != 8'd0) begin
      qi = 32'(a) / 32'(b);
      if (qi <= 32'd255) begin
        e.q = 8'(qi);
        e.r = RemEn ? 8'(32'(a) % 32'(b)) : 8'h00;
        e.o = 1'b0;
      end
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare process: every cycle the result is presented, check it against the model.
  initial begin
    bit   prev_ov = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        prev_ov = 1'b0;
      end else begin
        if (in_valid && in_ready) exp_q.push_back(model(dividend, divisor, cyc + 1));
        if (out_valid) begin
          chk("in_ready_low_in_done", 32'(in_ready), 32'd0);
          if (exp_q.size() == 0) begin
            chk("spurious_out_valid", 32'(out_valid), 32'd0);
          end else begin
            e = exp_q[0];
            chk("result_q_r_ovf", {15'd0, quotient, remainder, ovf}, {15'd0, e.q, e.r, e.o});
            if (!prev_ov) chk("latency", 32'(cyc - e.acc), e.o ? 32'd1 : 32'd8);
            if (out_ready) void'(exp_q.pop_front());
          end
        end
        prev_ov = out_valid;
      end
    end
  end

  task automatic send(input logic [15:0] a, input logic [7:0] b);
    bit hs = 1'b0;
    int n = 0;
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    while (!hs && n < 50) begin
      @(negedge clk);
      hs = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!hs) chk("accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
    dividend = 16'($urandom);
    divisor  = 8'($urandom);
  endtask

  task automatic finish_op(input int stall, input bit pulse,
                           output logic [7:0] q, output logic [7:0] r, output logic o);
    bit seen = 1'b0;
    int n = 0;
    out_ready = (stall == 0);
    while (!seen && n < 50) begin
      @(negedge clk);
      seen = out_valid;
      n++;
    end
    q = quotient;
    r = remainder;
    o = ovf;
    if (!seen) begin
      chk("result_timeout", 32'd0, 32'd1);
      out_ready = 1'b0;
      @(posedge clk);
      #1;
      return;
    end
    if (stall == 0) begin
      @(posedge clk);
      #1;
    end else begin
      repeat (stall) begin
        @(posedge clk);
        #1;
        in_valid = pulse;
        dividend = 16'd9;
        divisor  = 8'd3;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
    end
    out_ready = 1'b0;
  endtask

  task automatic op(input logic [15:0] a, input logic [7:0] b, input int stall,
                    input logic [7:0] eq, input logic [7:0] er, input logic eo, input string nm);
    logic [7:0] q, r;
    logic       o;
    send(a, b);
    finish_op(stall, 1'b0, q, r, o);
    chk({nm, "_q"}, 32'(q), 32'(eq));
    chk({nm, "_r"}, 32'(r), RemEn ? 32'(er) : 32'd0);
    chk({nm, "_ovf"}, 32'(o), 32'(eo));
  endtask

  initial begin
    logic [7:0]  q, r, b;
    logic        o;
    logic [15:0] a;
    int          mode;

    #2;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_outputs", {15'd0, quotient, remainder, ovf}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    op(16'd1000, 8'd7, 0, 8'd142, 8'd6, 1'b0, "d1000_7");

    // in_valid pulses while BUSY and while stalled in DONE must be ignored.
    send(16'd65025, 8'd255);
    repeat (3) begin
      in_valid = 1'b1;
      dividend = 16'd9;
      divisor  = 8'd3;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    finish_op(5, 1'b1, q, r, o);
    chk("d65025_255_q", 32'(q), 32'd255);
    chk("d65025_255_r", 32'(r), 32'd0);
    chk("d65025_255_ovf", 32'(o), 32'd0);

    op(16'd255, 8'd16, 1, 8'd15, 8'd15, 1'b0, "d255_16");
    op(16'h1234, 8'h12, 0, 8'hFF, 8'h00, 1'b1, "ovf_hi_eq");
    op(16'd255, 8'd0, 2, 8'hFF, 8'h00, 1'b1, "div_zero");
    op(16'h00FF, 8'd1, 0, 8'hFF, 8'h00, 1'b0, "max_quot");
    op(16'h0100, 8'd1, 0, 8'hFF, 8'h00, 1'b1, "ovf_edge");
    op(16'd0, 8'd5, 0, 8'd0, 8'd0, 1'b0, "zero_dvd");

    // Reset in the middle of a division: result discarded, nothing appears afterwards.
    send(16'd1000, 8'd7);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_outputs", {15'd0, quotient, remainder, ovf}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk("midrst_no_spurious", 32'(out_valid), 32'd0);
    op(16'd100, 8'd9, 0, 8'd11, 8'd1, 1'b0, "after_rst");

    for (int i = 0; i < 3000; i++) begin
      b = 8'($urandom_range(0, 255));
      mode = int'($urandom_range(0, 3));
      if (mode != 0 && b != 8'd0) a = 16'($urandom_range(0, int'(b) * 256 - 1));
      else a = 16'($urandom_range(0, 65535));
      send(a, b);
      finish_op(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), q, r, o);
    end

    repeat (5) @(posedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog: run did not complete, t=%0t", $time);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
